uart_fifo_tx: RTL

Serial transmit engine that drains the read side of the on-chip byte FIFO and shifts each entry out as an asynchronous UART frame. Frame format: start bit, data bits LSB first, optional even parity, one stop bit. Sits between the CPU-facing TX FIFO and the board serial pin, with CTS flow control and an enable gate.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_counter.sv | 40 ++++
 rtl/uart_fifo_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line-level symbol values.
// Used by the transmitter and intended for reuse by the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Symbol timer: counts 0..cycles_per_symbol-1 while running and flags the
// final cycle of each symbol. A clear restarts the count for a new frame.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int cycles_per_symbol = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic symbol_end
);

    localparam int              CNT_W = $clog2(cycles_per_symbol);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(cycles_per_symbol - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Baud counter: cleared on fetch, wraps at the end of every symbol.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (run) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + ONE;
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign symbol_end = run & (r_count == LAST);

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops bytes from a FIFO and serialises them as
// start / data (LSB first) / optional even parity / stop frames.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int data_width = 8,
    parameter int clock_freq = 50_000_000,
    parameter int baud_rate  = 115_200,
    parameter int parity_en  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cts_n,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int               cycles_per_symbol = clock_freq / baud_rate;
    localparam int               IDX_W    = (data_width > 1) ? $clog2(data_width) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(data_width - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    function automatic logic even_parity(input logic [data_width-1:0] d);
        return ^d;
    endfunction

    uart_state_e           r_state;
    uart_state_e           w_next_state;
    logic [data_width-1:0] r_shift;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_parity;
    logic                  r_serial;
    logic                  r_busy;
    logic                  r_tx_done;
    logic                  w_line;
    logic                  w_fetch;
    logic                  w_fetch_point;
    logic                  w_symbol_end;
    logic                  w_run;

    // Pops happen only at fetch points; reset masks the strobe so nothing is lost.
    assign w_fetch       = enable & ~cts_n & ~fifo_empty;
    assign w_fetch_point = (r_state == IDLE) | ((r_state == STOP) & w_symbol_end);
    assign fifo_rd_en    = reset & w_fetch & w_fetch_point;
    assign w_run         = (r_state != IDLE);

    uart_baud_counter #(
        .cycles_per_symbol(cycles_per_symbol)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .clear     (fifo_rd_en),
        .run       (w_run),
        .symbol_end(w_symbol_end)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; symbols advance on the baud counter wrap.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (fifo_rd_en) w_next_state = START;
                else            w_next_state = IDLE;
            end
            START: begin
                if (w_symbol_end) w_next_state = DATA;
                else              w_next_state = START;
            end
            DATA: begin
                if (w_symbol_end && (r_bit_idx == LAST_IDX))
                    w_next_state = (parity_en != 0) ? PARITY : STOP;
                else
                    w_next_state = DATA;
            end
            PARITY: begin
                if (w_symbol_end) w_next_state = STOP;
                else              w_next_state = PARITY;
            end
            STOP: begin
                if (fifo_rd_en)        w_next_state = START;
                else if (w_symbol_end) w_next_state = IDLE;
                else                   w_next_state = STOP;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Shift register, bit index and parity capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_parity  <= 1'b0;
        end else if (fifo_rd_en) begin
            r_shift   <= fifo_dout;
            r_bit_idx <= '0;
            r_parity  <= even_parity(fifo_dout);
        end else if ((r_state == DATA) && w_symbol_end) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + IDX_ONE;
            r_parity  <= r_parity;
        end else begin
            r_shift   <= r_shift;
            r_bit_idx <= r_bit_idx;
            r_parity  <= r_parity;
        end
    end

    // Line level for the current state.
    always_comb begin
        w_line = LINE_IDLE;
        case (r_state)
            IDLE:    w_line = LINE_IDLE;
            START:   w_line = START_BIT;
            DATA:    w_line = r_shift[0];
            PARITY:  w_line = r_parity;
            STOP:    w_line = STOP_BIT;
            default: w_line = LINE_IDLE;
        endcase
    end

    // Registered outputs: outputs lag the state by one clock, so tx_done
    // lines up with the last stop-bit cycle seen on the pin.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_serial  <= LINE_IDLE;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_serial  <= w_line;
            r_busy    <= (r_state != IDLE);
            r_tx_done <= (r_state == STOP) & w_symbol_end;
        end
    end

    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign tx_done    = r_tx_done;

endmodule
